// File: rtl/registro_id_ex.sv
// registro_id_ex
// ID/EX pipeline register with integrated load-use hazard detection.
// Every cycle it captures the ID-stage operands, immediate, register
// specifiers and control bits and presents them to EX. A load in EX whose
// destination (ex_rt) is read by the instruction in ID freezes PC and IF/ID
// for one cycle and inserts a bubble into EX.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               taken branch/jump: instruction entering EX becomes a bubble
//   id_*                decode-stage specifiers, data and control bits
//   ex_*                registered copies of every id_* input
//   ex_valid            1 = real instruction in EX, 0 = bubble
//   pc_esc, ifid_esc    PC / IF-ID write enables (combinational, low on hazard)
//   stall_cnt           saturating load-use stall counter (HAZARD_STATS_EN only)
//
// Build option: define HAZARD_STATS_EN to add the stall_cnt port and counter.
module registro_id_ex #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_dato_a,
  input  logic [DATA_W-1:0] id_dato_b,
  input  logic [DATA_W-1:0] id_inm,
  input  logic              id_esc_reg,
  input  logic              id_lee_mem,
  input  logic              id_esc_mem,
  input  logic              id_mem_a_reg,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [1:0]        id_alu_op,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_dato_a,
  output logic [DATA_W-1:0] ex_dato_b,
  output logic [DATA_W-1:0] ex_inm,
  output logic              ex_esc_reg,
  output logic              ex_lee_mem,
  output logic              ex_esc_mem,
  output logic              ex_mem_a_reg,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic [1:0]        ex_alu_op,
  output logic              ex_valid,
  output logic              pc_esc,
`ifdef HAZARD_STATS_EN
  output logic              ifid_esc,
  output logic [15:0]       stall_cnt
`else
  output logic              ifid_esc
`endif
);

  logic [REG_W-1:0]  r_rs, r_rt, r_rd;
  logic [DATA_W-1:0] r_dato_a, r_dato_b, r_inm;
  logic              r_esc_reg, r_lee_mem, r_esc_mem, r_mem_a_reg;
  logic              r_alu_src, r_reg_dst;
  logic [1:0]        r_alu_op;
  logic              r_valid;
  logic              w_riesgo;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign w_riesgo = r_valid & r_lee_mem & (r_rt != '0) &
                    ((r_rt == id_rs) | (r_rt == id_rt));

  // Flush does not gate the hold: the fetch unit resolves flush vs. PC hold.
  assign pc_esc   = ~w_riesgo;
  assign ifid_esc = ~w_riesgo;

  // Reset, flush and stall all load the same all-zero bubble; clearing the
  // specifiers too keeps the forwarding unit from matching on stale values.
  always_ff @(posedge clk) begin
    if (reset || flush || w_riesgo) begin
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_dato_a    <= '0;
      r_dato_b    <= '0;
      r_inm       <= '0;
      r_esc_reg   <= 1'b0;
      r_lee_mem   <= 1'b0;
      r_esc_mem   <= 1'b0;
      r_mem_a_reg <= 1'b0;
      r_alu_src   <= 1'b0;
      r_reg_dst   <= 1'b0;
      r_alu_op    <= 2'b00;
      r_valid     <= 1'b0;
    end else begin
      r_rs        <= id_rs;
      r_rt        <= id_rt;
      r_rd        <= id_rd;
      r_dato_a    <= id_dato_a;
      r_dato_b    <= id_dato_b;
      r_inm       <= id_inm;
      r_esc_reg   <= id_esc_reg;
      r_lee_mem   <= id_lee_mem;
      r_esc_mem   <= id_esc_mem;
      r_mem_a_reg <= id_mem_a_reg;
      r_alu_src   <= id_alu_src;
      r_reg_dst   <= id_reg_dst;
      r_alu_op    <= id_alu_op;
      r_valid     <= 1'b1;
    end
  end

  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_rd        = r_rd;
  assign ex_dato_a    = r_dato_a;
  assign ex_dato_b    = r_dato_b;
  assign ex_inm       = r_inm;
  assign ex_esc_reg   = r_esc_reg;
  assign ex_lee_mem   = r_lee_mem;
  assign ex_esc_mem   = r_esc_mem;
  assign ex_mem_a_reg = r_mem_a_reg;
  assign ex_alu_src   = r_alu_src;
  assign ex_reg_dst   = r_reg_dst;
  assign ex_alu_op    = r_alu_op;
  assign ex_valid     = r_valid;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_riesgo && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/registro_id_ex.md
# registro_id_ex

Pipeline register between decode (ID) and execute (EX) of the 5-stage datapath, with integrated load-use hazard detection. It captures register operands, immediate, register specifiers and control bits from ID every cycle and presents them to EX. The registered `Rs`/`Rt` feed the forwarding unit, and the registered destination and write-enable travel on to EX/MEM. When a load in EX targets a register read by the instruction in ID, it freezes PC and IF/ID and injects a one-cycle bubble.

## Interface
- `DATA_W`, 32, operand/immediate width
- `REG_W`, 5, register specifier width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `flush`  in  1  branch/jump taken; turn the instruction entering EX into a bubble
- `id_rs`, `id_rt`, `id_rd`  in  REG_W each  specifiers of instruction in ID
- `id_dato_a`, `id_dato_b`  in  DATA_W each  register-file read data
- `id_inm`  in  DATA_W  sign-extended immediate
- `id_esc_reg`, `id_lee_mem`, `id_esc_mem`, `id_mem_a_reg`, `id_alu_src`, `id_reg_dst`  in  1 each  control bits
- `id_alu_op`  in  2  ALU operation class
- `ex_*`  out  same widths  registered copies of every `id_*` input, including `ex_rs`/`ex_rt`, which drive forwarding `Rs`/`Rt`
- `ex_valid`  out  1  1 = real instruction in EX, 0 = bubble
- `pc_esc`  out  1  PC write enable (combinational)
- `ifid_esc`  out  1  IF/ID write enable (combinational)
- `stall_cnt`  out  16  load-use stall count (only with `HAZARD_STATS_EN`)

## Operation
- Hazard: `riesgo = ex_valid & ex_lee_mem & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt))`. Register 0 never causes a hazard.
- `pc_esc = ifid_esc = ~riesgo`. These are combinational from the registered EX state and the ID inputs.
- Per-edge priority:
  1. `reset` clears all `ex_*` to 0 and sets `ex_valid` to 0.
  2. `flush` loads a bubble.
  3. `riesgo` loads a bubble.
  4. Otherwise all `id_*` inputs are captured and `ex_valid` is set to 1.
- Bubble: `ex_esc_reg`, `ex_lee_mem`, `ex_esc_mem`, `ex_mem_a_reg`, `ex_valid` are 0. Data and specifier fields are also cleared to 0, so the downstream forwarding unit never matches on stale values.
- After a stall bubble, `riesgo` drops on the next cycle because `ex_valid` is 0. The held ID instruction is then captured, giving exactly one stall cycle per load-use pair.
- `flush` and `riesgo` in the same cycle: the result is a bubble and `pc_esc`/`ifid_esc` still follow `riesgo`. The fetch unit's flush logic has precedence over the PC hold.
- The block performs no arithmetic. All fields pass through at their declared widths.

## Timing
- Latency: 1 cycle from ID inputs to `ex_*`.
- Reset values: every `ex_*` = 0, `ex_valid` = 0, `stall_cnt` = 0. `pc_esc` and `ifid_esc` = 1 while the EX state is the reset bubble.
- Reset asserted mid-stall overrides the stall. On the following cycle `pc_esc` = 1.
- Back-to-back loads, each feeding the next: each pair stalls one cycle, and there is no deadlock.

## Configuration
- `HAZARD_STATS_EN` defined: `stall_cnt` increments on each edge where `riesgo` = 1 and `reset` = 0. It saturates at 16'hFFFF and is cleared by `reset`.
- `HAZARD_STATS_EN` undefined: `stall_cnt` is absent from the port list and the counter logic is not built. All other behaviour is identical.

## Test plan
- Reset: hold `reset` for 2 cycles with random ID inputs. Required: all `ex_*` = 0, `ex_valid` = 0, `pc_esc` = 1, `ifid_esc` = 1.
- Pass-through: `id_rs` = 3, `id_rt` = 4, `id_dato_a` = 32'h1234, `id_esc_reg` = 1, no load in EX. Required: next cycle `ex_rs` = 3, `ex_rt` = 4, `ex_dato_a` = 32'h1234, `ex_valid` = 1.
- Load-use: `lw` captured with `ex_rt` = 2 and `ex_lee_mem` = 1, followed by an ID instruction with `id_rs` = 2.
  - Required: `pc_esc` = `ifid_esc` = 0 for exactly 1 cycle.
  - The next EX state is a bubble (`ex_valid` = 0, `ex_esc_reg` = 0).
  - The cycle after that captures `ex_rs` = 2. `stall_cnt` = 1 when `HAZARD_STATS_EN` is defined.
- Register zero: load in EX with `ex_rt` = 0 and `id_rt` = 0. Required: no stall, `pc_esc` = 1.
- Flush: `flush` = 1 with valid ID inputs (`id_esc_mem` = 1). Required: next cycle `ex_esc_mem` = 0, `ex_valid` = 0, `pc_esc` = 1.
- Flush and hazard together: both active. Required: a bubble, `pc_esc` = 0 during that cycle, and `stall_cnt` increments by 1.
